// File: rtl/mem_bus_pkg.sv
// Shared constants for the arbiter-to-main-memory burst bus.
// Latency: n/a (definitions only).
// Backpressure: n/a; the bus carries no ready signal.
package mem_bus_pkg;

  // Default widths of the burst bus and the on-chip word memory
  localparam int MAIN_MEM_ADDR_WIDTH_D = 32;
  localparam int BURST_WIDTH_D         = 6;
  localparam int DATA_WIDTH_D          = 16;
  localparam int MEM_DEPTH_D           = 1024;

  // Beat direction on w_rw
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Responder FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BURST  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/mem_sram_sp.sv
// Single-port synchronous word RAM, write-first.
// Latency: read data registered, valid one cycle after the enabled read.
// Backpressure: none; one access per enabled cycle.
module mem_sram_sp #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  w_clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Storage is never reset so contents survive a bus reset; a write also
  // forwards its data to the read register (write-first).
  always_ff @(posedge w_clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: header, then N address beats executed against the word RAM.
// Latency: header->first beat 1 cycle, read beat->data 1 cycle, last beat->w_done 1 cycle.
// Backpressure: none; exactly one beat is consumed per cycle while busy.
module main_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int MAIN_MEM_ADDR_WIDTH = MAIN_MEM_ADDR_WIDTH_D,
  parameter int BURST_WIDTH         = BURST_WIDTH_D,
  parameter int DATA_WIDTH          = DATA_WIDTH_D,
  parameter int MEM_DEPTH           = MEM_DEPTH_D
) (
  input  logic                           w_clock,
  input  logic                           w_reset,
  input  logic [BURST_WIDTH-1:0]         w_burst,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr,
  input  logic                           w_rw,
  input  logic [DATA_WIDTH-1:0]          w_wdata,
  output logic [DATA_WIDTH-1:0]          w_rdata,
  output logic                           w_rvalid,
  output logic                           w_busy,
  output logic                           w_done,
  output logic                           w_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic                   rst_meta;
  logic                   rst_int;
  logic [1:0]             state;
  logic [BURST_WIDTH-1:0] len_q;
  logic [BURST_WIDTH-1:0] cnt_q;
  logic                   rd_vld_q;
  logic                   rd_oor_q;
  logic                   err_q;
  logic [DATA_WIDTH-1:0]  ram_q;

  logic beat_vld;
  logic hdr_vld;
  logic in_range;
  logic last_beat;
  logic ram_en;
  logic ram_we;

  // Reset asserts immediately, releases two clock edges after w_reset drops
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  assign beat_vld  = (state == ST_BURST);
  assign hdr_vld   = (state == ST_IDLE) && (w_burst != '0);
  // Full-width unsigned compare: addresses past the array never alias back in
  assign in_range  = (w_addr < MAIN_MEM_ADDR_WIDTH'(MEM_DEPTH));
  assign last_beat = beat_vld && (cnt_q == (len_q - BURST_WIDTH'(1)));
  assign ram_en    = beat_vld && in_range;
  assign ram_we    = ram_en && (w_rw == RW_WRITE);

  mem_sram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_W     (IDX_W)
  ) u_sram (
    .w_clock (w_clock),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (w_addr[IDX_W-1:0]),
    .wdata   (w_wdata),
    .rdata   (ram_q)
  );

  // Burst sequencer: latch length on header, count beats, one FINISH cycle
  always_ff @(posedge w_clock or posedge rst_int) begin
    if (rst_int) begin
      state <= ST_IDLE;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_vld) begin
            len_q <= w_burst;
            cnt_q <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          cnt_q <= cnt_q + BURST_WIDTH'(1);
          if (last_beat) state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Track read beats for next-cycle data and keep the sticky range error
  always_ff @(posedge w_clock or posedge rst_int) begin
    if (rst_int) begin
      rd_vld_q <= 1'b0;
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_vld_q <= beat_vld && (w_rw == RW_READ);
      rd_oor_q <= beat_vld && (w_rw == RW_READ) && !in_range;
      if (hdr_vld) begin
        err_q <= 1'b0;
      end else if (beat_vld && !in_range) begin
        err_q <= 1'b1;
      end
    end
  end

  // Out-of-range reads and idle cycles present zero data
  assign w_rdata  = (rd_vld_q && !rd_oor_q) ? ram_q : '0;
  assign w_rvalid = rd_vld_q;
  assign w_done   = (state == ST_FINISH);
  // Busy covers the accepted header cycle as well as every beat cycle
  assign w_busy   = !rst_int && (beat_vld || hdr_vld);
  assign w_err    = err_q;

endmodule

// File: tb/tb_main_mem_responder.sv
`timescale 1ns/1ps
module tb_main_mem_responder;
  import mem_bus_pkg::*;

  localparam int AW    = 32;
  localparam int BW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] d;
  } beat_t;

  logic          w_clock = 1'b0;
  logic          w_reset;
  logic [BW-1:0] w_burst;
  logic [AW-1:0] w_addr;
  logic          w_rw;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;
  logic          w_rvalid;
  logic          w_busy;
  logic          w_done;
  logic          w_err;

  always #5 w_clock = ~w_clock;

  main_mem_responder #(
    .MAIN_MEM_ADDR_WIDTH (AW),
    .BURST_WIDTH         (BW),
    .DATA_WIDTH          (DW),
    .MEM_DEPTH           (DEPTH)
  ) dut (
    .w_clock  (w_clock),
    .w_reset  (w_reset),
    .w_burst  (w_burst),
    .w_addr   (w_addr),
    .w_rw     (w_rw),
    .w_wdata  (w_wdata),
    .w_rdata  (w_rdata),
    .w_rvalid (w_rvalid),
    .w_busy   (w_busy),
    .w_done   (w_done),
    .w_err    (w_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done_seen = 0;
  int n_done_exp  = 0;
  bit mon_en   = 1'b0;
  bit exp_busy = 1'b0;
  bit model_err = 1'b0;

  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] rd_q [$];
  logic          err_done_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge w_clock);
    #1;
  endtask

  function automatic beat_t mk(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d);
    beat_t b;
    b.addr = a;
    b.rw   = rw;
    b.d    = d;
    return b;
  endfunction

  // Reference behaviour of one beat: memory update, read result, sticky error
  function automatic void model_beat(input beat_t b);
    bit inr;
    inr = (b.addr < AW'(DEPTH));
    if (!inr) model_err = 1'b1;
    if (b.rw == RW_WRITE) begin
      if (inr) mem_m[int'(b.addr)] = b.d;
    end else begin
      rd_q.push_back(inr ? mem_m[int'(b.addr)] : '0);
    end
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      w_burst  = '0;
      w_addr   = AW'($urandom_range(0, 31));
      w_rw     = 1'($urandom);
      w_wdata  = DW'($urandom);
      exp_busy = 1'b0;
      tick();
    end
  endtask

  // Header cycle, N beat cycles, FINISH cycle with an optional (ignored) header
  task automatic run_burst(input beat_t bq[$], input logic [BW-1:0] fin_hdr);
    int n;
    n = bq.size();
    w_burst  = BW'(n);
    w_addr   = AW'($urandom);
    w_rw     = 1'($urandom);
    w_wdata  = DW'($urandom);
    exp_busy = 1'b1;
    model_err = 1'b0;
    tick();
    check("err_cleared_by_header", w_err, 0);
    foreach (bq[i]) begin
      w_burst  = BW'($urandom);
      w_addr   = bq[i].addr;
      w_rw     = bq[i].rw;
      w_wdata  = bq[i].d;
      exp_busy = 1'b1;
      model_beat(bq[i]);
      if (i == n - 1) begin
        err_done_q.push_back(model_err);
        n_done_exp++;
      end
      tick();
    end
    w_burst  = fin_hdr;
    w_addr   = AW'($urandom);
    w_rw     = 1'($urandom);
    exp_busy = 1'b0;
    tick();
    w_burst = '0;
  endtask

  // Monitor: compares every DUT cycle against the scoreboard queues
  initial begin
    forever begin
      @(negedge w_clock);
      if (mon_en) begin
        check("busy", w_busy, exp_busy);
        if (w_rvalid) begin
          if (rd_q.size() == 0) flag("rvalid_unexpected");
          else check("rdata", w_rdata, rd_q.pop_front());
        end else begin
          check("rdata_zero_when_invalid", w_rdata, 0);
        end
        if (w_done) begin
          n_done_seen++;
          if (err_done_q.size() == 0) flag("done_unexpected");
          else check("err_at_done", w_err, err_done_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t bq[$];
    logic [DW-1:0] d;
    w_reset = 1'b1;
    w_burst = BW'(5);
    w_addr  = '0;
    w_rw    = 1'b0;
    w_wdata = '0;
    repeat (3) tick();
    check("reset_rvalid", w_rvalid, 0);
    check("reset_rdata",  w_rdata,  0);
    check("reset_busy",   w_busy,   0);
    check("reset_done",   w_done,   0);
    check("reset_err",    w_err,    0);
    w_burst = '0;
    w_reset = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;

    // Write burst 10..13 <= A0..A3
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(mk(AW'(10 + i), RW_WRITE, DW'(16'hA0 + i)));
    run_burst(bq, '0);
    idle(1);

    // Read them back
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(mk(AW'(10 + i), RW_READ, '0));
    run_burst(bq, '0);
    idle(1);

    // Mixed with out-of-range read; error stays sticky in IDLE
    bq.delete();
    bq.push_back(mk(AW'(5), RW_WRITE, 16'h0055));
    bq.push_back(mk(AW'(5), RW_READ, '0));
    bq.push_back(mk(AW'(1024), RW_READ, '0));
    run_burst(bq, '0);
    idle(1);
    check("err_sticky_idle", w_err, 1);
    bq.delete();
    bq.push_back(mk(AW'(1023), RW_WRITE, 16'h1234));
    run_burst(bq, '0);

    // Zero header for 5 cycles: writes presented while idle must not land
    for (int i = 0; i < 5; i++) begin
      w_burst  = '0;
      w_addr   = AW'(10 + (i % 4));
      w_rw     = RW_WRITE;
      w_wdata  = DW'($urandom);
      exp_busy = 1'b0;
      tick();
    end
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(mk(AW'(10 + i), RW_READ, '0));
    bq.push_back(mk(AW'(1023), RW_READ, '0));
    // Header held during FINISH must be ignored; next burst starts right after
    run_burst(bq, BW'(3));
    bq.delete();
    bq.push_back(mk(AW'(7), RW_WRITE, 16'h7777));
    bq.push_back(mk(AW'(7), RW_READ, '0));
    bq.push_back(mk(AW'(32'hFFFF_FFFF), RW_WRITE, 16'hDEAD));
    run_burst(bq, '0);
    idle(2);

    // Reset mid-burst: three writes, one read whose data must be dropped
    w_burst  = BW'(8);
    exp_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      w_burst  = '0;
      w_addr   = AW'(100 + (i % 3));
      w_rw     = (i == 3) ? RW_READ : RW_WRITE;
      w_wdata  = DW'($urandom);
      if (i < 3) model_beat(mk(w_addr, w_rw, w_wdata));
      tick();
    end
    w_reset  = 1'b1;
    exp_busy = 1'b0;
    #1;
    check("midreset_rvalid", w_rvalid, 0);
    check("midreset_rdata",  w_rdata,  0);
    check("midreset_busy",   w_busy,   0);
    check("midreset_done",   w_done,   0);
    tick();
    tick();
    w_reset = 1'b0;
    idle(3);
    bq.delete();
    bq.push_back(mk(AW'(100), RW_READ, '0));
    bq.push_back(mk(AW'(101), RW_READ, '0));
    run_burst(bq, '0);
    bq.delete();
    bq.push_back(mk(AW'(102), RW_READ, '0));
    run_burst(bq, '0);

    // Max burst: 63 alternating write/read beats at address 0
    bq.delete();
    for (int i = 0; i < 63; i++) begin
      d = DW'($urandom);
      bq.push_back(mk('0, (i % 2 == 1) ? RW_READ : RW_WRITE, d));
    end
    run_burst(bq, '0);
    idle(1);

    // Randomised bursts
    for (int b = 0; b < 25; b++) begin
      int n;
      n = $urandom_range(1, 16);
      bq.delete();
      for (int i = 0; i < n; i++) begin
        logic [AW-1:0] a;
        logic rw;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      a = AW'(1024);
        else if (sel == 1) a = AW'($urandom_range(1025, 32'h7FFF_FFFF)) | 32'h8000_0000;
        else if (sel == 2) a = AW'(1023);
        else               a = AW'($urandom_range(0, 63));
        rw = 1'($urandom);
        if (rw == RW_READ && a < AW'(DEPTH) && !mem_m.exists(int'(a))) rw = RW_WRITE;
        if (rw == RW_WRITE && a < AW'(DEPTH)) mem_m[int'(a)] = mem_m.exists(int'(a)) ? mem_m[int'(a)] : '0;
        bq.push_back(mk(a, rw, DW'($urandom)));
        // Keep the model's existence table in step so later reads in this burst are legal
      end
      run_burst(bq, BW'($urandom));
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("rd_queue_drained", rd_q.size(), 0);
    check("done_queue_drained", err_done_q.size(), 0);
    check("done_count", n_done_seen, n_done_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
